// File: rtl/sq_drain_pkg.sv
// sq_drain_pkg: shared types for the store-queue drain unit.
//   sq_drain_state_e : drain FSM states (IDLE -> REQ -> WAIT -> IDLE)
//   sq_drain_req_t   : latched write request (addr, data, byte enables, ROB tag)
// The struct field widths follow the default top-level parameters.
package sq_drain_pkg;

  localparam int SQD_ROB_IDX_W = 6;
  localparam int SQD_ADDR_W    = 32;
  localparam int SQD_DATA_W    = 32;
  localparam int SQD_BE_W      = SQD_DATA_W / 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } sq_drain_state_e;

  typedef struct packed {
    logic [SQD_ADDR_W-1:0]    addr;
    logic [SQD_DATA_W-1:0]    data;
    logic [SQD_BE_W-1:0]      be;
    logic [SQD_ROB_IDX_W-1:0] rob_tag;
  } sq_drain_req_t;

endpackage

// File: rtl/sq_drain_chk.sv
// sq_drain_chk: protocol checks for the drain unit's environment.
//   Retired count never exceeds the queue depth, a retired store is always
//   visible at the SQ head, responses only arrive while waiting for one, and
//   a flush outside WAIT never discards retired stores.
module sq_drain_chk
  import sq_drain_pkg::*;
#(
  parameter int SQ_DEPTH = 16,
  parameter int CNT_W    = 5,
  parameter int CW_W     = 2
) (
  input logic            clk_i,
  input logic            rst_ni,
  input logic            flush_i,
  input logic [CW_W-1:0] commit_i,
  input logic [CNT_W-1:0] pending_i,
  input logic            head_valid_i,
  input logic            resp_valid_i,
  input sq_drain_state_e state_i
);

  a_pend_bound : assert property (@(posedge clk_i) disable iff (!rst_ni)
    (int'(pending_i) + int'(commit_i)) <= SQ_DEPTH);

  a_head_valid : assert property (@(posedge clk_i) disable iff (!rst_ni)
    (pending_i != {CNT_W{1'b0}}) |-> head_valid_i);

  a_resp_in_wait : assert property (@(posedge clk_i) disable iff (!rst_ni)
    resp_valid_i |-> (state_i == WAIT));

  // In WAIT the in-flight store is absorbed, so only other states are checked.
  a_flush_safe : assert property (@(posedge clk_i) disable iff (!rst_ni)
    (flush_i && (state_i != WAIT)) |-> (pending_i == {CNT_W{1'b0}}));

endmodule

// File: rtl/sq_drain_perf.sv
// sq_drain_perf: free-running drain performance counters (wrap modulo 2^32,
// cleared only by reset). Built only when SQ_DRAIN_PERF_EN is defined.
//   clk_i, rst_ni   : clock, synchronous active-low reset
//   drain_i         : one SQ entry popped this cycle
//   stall_i         : request presented but not accepted this cycle
//   drained_o       : number of popped entries
//   stall_o         : number of stalled request cycles
module sq_drain_perf (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        drain_i,
  input  logic        stall_i,
  output logic [31:0] drained_o,
  output logic [31:0] stall_o
);

  logic [31:0] drained_r;
  logic [31:0] stall_r;

  // Count pops and stalled request cycles.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      drained_r <= 32'd0;
      stall_r   <= 32'd0;
    end else begin
      if (drain_i) drained_r <= drained_r + 32'd1;
      if (stall_i) stall_r   <= stall_r + 32'd1;
    end
  end

  assign drained_o = drained_r;
  assign stall_o   = stall_r;

endmodule

// File: rtl/sq_drain.sv
// sq_drain: store-queue drain unit. Counts stores retired by the ROB, takes
// the SQ head once retired, writes it to the data-memory port with a
// valid/ready request and a response, then pops the SQ head.
// Optional feature macro: SQ_DRAIN_PERF_EN adds perf_drained_o / perf_stall_o.
// Ports:
//   clk_i, rst_ni            : clock, synchronous active-low reset
//   flush_i                  : pipeline flush
//   commit_store_cnt_i       : stores retired this cycle
//   sq_head_*                : SQ head entry
//   sq_pop_valid_o           : pop SQ head (on accepted response)
//   dmem_req_*               : write request handshake and payload
//   dmem_resp_valid_i/err_i  : write response
//   store_fault_*            : error pulse and held faulting tag/addr
//   pending_cnt_o            : retired-but-not-drained stores
//   idle_o                   : IDLE with nothing pending
module sq_drain
  import sq_drain_pkg::*;
#(
  parameter int ROB_IDX_WIDTH = 6,
  parameter int ADDR_WIDTH    = 32,
  parameter int DATA_WIDTH    = 32,
  parameter int SQ_DEPTH      = 16,
  parameter int COMMIT_WIDTH  = 2
) (
  input  logic                              clk_i,
  input  logic                              rst_ni,
  input  logic                              flush_i,
  input  logic [$clog2(COMMIT_WIDTH+1)-1:0] commit_store_cnt_i,
  input  logic                              sq_head_valid_i,
  input  logic [ROB_IDX_WIDTH-1:0]          sq_head_rob_tag_i,
  input  logic [ADDR_WIDTH-1:0]             sq_head_addr_i,
  input  logic [DATA_WIDTH-1:0]             sq_head_data_i,
  input  logic [DATA_WIDTH/8-1:0]           sq_head_be_i,
  output logic                              sq_pop_valid_o,
  output logic                              dmem_req_valid_o,
  input  logic                              dmem_req_ready_i,
  output logic [ADDR_WIDTH-1:0]             dmem_req_addr_o,
  output logic [DATA_WIDTH-1:0]             dmem_req_wdata_o,
  output logic [DATA_WIDTH/8-1:0]           dmem_req_wstrb_o,
  input  logic                              dmem_resp_valid_i,
  input  logic                              dmem_resp_err_i,
  output logic                              store_fault_o,
  output logic [ROB_IDX_WIDTH-1:0]          store_fault_rob_tag_o,
  output logic [ADDR_WIDTH-1:0]             store_fault_addr_o,
  output logic [$clog2(SQ_DEPTH+1)-1:0]     pending_cnt_o,
  output logic                              idle_o
`ifdef SQ_DRAIN_PERF_EN
  ,output logic [31:0]                      perf_drained_o
  ,output logic [31:0]                      perf_stall_o
`endif
);

  localparam int CNT_W = $clog2(SQ_DEPTH + 1);
  localparam int CW_W  = $clog2(COMMIT_WIDTH + 1);

  sq_drain_state_e          state_r;
  sq_drain_state_e          state_next_s;
  logic [CNT_W-1:0]         pending_r;
  logic [CNT_W-1:0]         pending_next_s;
  sq_drain_req_t            req_r;
  logic                     drop_r;
  logic                     latch_s;
  logic                     resp_in_wait_s;
  logic                     fault_r;
  logic [ROB_IDX_WIDTH-1:0] fault_tag_r;
  logic [ADDR_WIDTH-1:0]    fault_addr_r;

  assign resp_in_wait_s = (state_r == WAIT) && dmem_resp_valid_i;
  assign latch_s        = (state_r == IDLE) && (state_next_s == REQ);

  // State register.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic; flush drops an unaccepted request, WAIT still absorbs
  // the response of the store already on the bus.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (!flush_i && (pending_r != {CNT_W{1'b0}}) && sq_head_valid_i) begin
          state_next_s = REQ;
        end else begin
          state_next_s = IDLE;
        end
      end
      REQ: begin
        if (flush_i) begin
          state_next_s = IDLE;
        end else if (dmem_req_ready_i) begin
          state_next_s = WAIT;
        end else begin
          state_next_s = REQ;
        end
      end
      WAIT: begin
        if (dmem_resp_valid_i) begin
          state_next_s = IDLE;
        end else begin
          state_next_s = WAIT;
        end
      end
      default: state_next_s = IDLE;
    endcase
  end

  // Output decode; the pop is suppressed once the SQ has been flushed.
  always_comb begin
    dmem_req_valid_o = 1'b0;
    sq_pop_valid_o   = 1'b0;
    idle_o           = 1'b0;
    case (state_r)
      IDLE:    idle_o           = (pending_r == {CNT_W{1'b0}});
      REQ:     dmem_req_valid_o = 1'b1;
      WAIT:    sq_pop_valid_o   = dmem_resp_valid_i && !flush_i && !drop_r;
      default: idle_o           = 1'b0;
    endcase
  end

  // Retired-but-not-drained count; commit and pop apply in the same cycle.
  always_comb begin
    pending_next_s = pending_r;
    if (flush_i) begin
      pending_next_s = {CNT_W{1'b0}};
    end else begin
      pending_next_s = pending_r + CNT_W'(commit_store_cnt_i)
                     - CNT_W'(sq_pop_valid_o);
    end
  end

  // Pending counter register.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      pending_r <= {CNT_W{1'b0}};
    end else begin
      pending_r <= pending_next_s;
    end
  end

  // Request payload: captured from the SQ head when leaving IDLE, held
  // stable through REQ and WAIT.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      req_r <= '0;
    end else if (latch_s) begin
      req_r.addr    <= sq_head_addr_i;
      req_r.data    <= sq_head_data_i;
      req_r.be      <= sq_head_be_i;
      req_r.rob_tag <= sq_head_rob_tag_i;
    end
  end

  // Remembers a flush seen in WAIT so the later response does not pop.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      drop_r <= 1'b0;
    end else if ((state_r == WAIT) && !dmem_resp_valid_i) begin
      drop_r <= drop_r | flush_i;
    end else begin
      drop_r <= 1'b0;
    end
  end

  // Fault pulse plus faulting tag/addr, held until the next fault.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      fault_r      <= 1'b0;
      fault_tag_r  <= {ROB_IDX_WIDTH{1'b0}};
      fault_addr_r <= {ADDR_WIDTH{1'b0}};
    end else begin
      fault_r <= resp_in_wait_s && dmem_resp_err_i;
      if (resp_in_wait_s && dmem_resp_err_i) begin
        fault_tag_r  <= req_r.rob_tag;
        fault_addr_r <= req_r.addr;
      end
    end
  end

  assign dmem_req_addr_o       = req_r.addr;
  assign dmem_req_wdata_o      = req_r.data;
  assign dmem_req_wstrb_o      = req_r.be;
  assign store_fault_o         = fault_r;
  assign store_fault_rob_tag_o = fault_tag_r;
  assign store_fault_addr_o    = fault_addr_r;
  assign pending_cnt_o         = pending_r;

`ifdef SQ_DRAIN_PERF_EN
  sq_drain_perf u_perf (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .drain_i   (sq_pop_valid_o),
    .stall_i   (dmem_req_valid_o && !dmem_req_ready_i),
    .drained_o (perf_drained_o),
    .stall_o   (perf_stall_o)
  );
`endif

  sq_drain_chk #(
    .SQ_DEPTH (SQ_DEPTH),
    .CNT_W    (CNT_W),
    .CW_W     (CW_W)
  ) u_chk (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .flush_i      (flush_i),
    .commit_i     (commit_store_cnt_i),
    .pending_i    (pending_r),
    .head_valid_i (sq_head_valid_i),
    .resp_valid_i (dmem_resp_valid_i),
    .state_i      (state_r)
  );

endmodule

// File: tb/tb_sq_drain.sv
// tb_sq_drain: randomized and directed bench for sq_drain. The reference is a
// queue-level model of the store queue: retired count, in-flight store and
// expected fault report.
module tb_sq_drain;

  typedef struct {
    logic [5:0]  tag;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst_ni;
  logic        flush;
  logic [1:0]  commit;
  logic        head_valid;
  logic [5:0]  head_tag;
  logic [31:0] head_addr;
  logic [31:0] head_data;
  logic [3:0]  head_be;
  logic        pop;
  logic        req_valid;
  logic        ready;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_wstrb;
  logic        resp_valid;
  logic        resp_err;
  logic        fault;
  logic [5:0]  fault_tag;
  logic [31:0] fault_addr;
  logic [4:0]  pending;
  logic        idle;
`ifdef SQ_DRAIN_PERF_EN
  logic [31:0] perf_drained;
  logic [31:0] perf_stall;
`endif

  sq_drain dut (
    .clk_i                 (clk),
    .rst_ni                (rst_ni),
    .flush_i               (flush),
    .commit_store_cnt_i    (commit),
    .sq_head_valid_i       (head_valid),
    .sq_head_rob_tag_i     (head_tag),
    .sq_head_addr_i        (head_addr),
    .sq_head_data_i        (head_data),
    .sq_head_be_i          (head_be),
    .sq_pop_valid_o        (pop),
    .dmem_req_valid_o      (req_valid),
    .dmem_req_ready_i      (ready),
    .dmem_req_addr_o       (req_addr),
    .dmem_req_wdata_o      (req_wdata),
    .dmem_req_wstrb_o      (req_wstrb),
    .dmem_resp_valid_i     (resp_valid),
    .dmem_resp_err_i       (resp_err),
    .store_fault_o         (fault),
    .store_fault_rob_tag_o (fault_tag),
    .store_fault_addr_o    (fault_addr),
    .pending_cnt_o         (pending),
    .idle_o                (idle)
`ifdef SQ_DRAIN_PERF_EN
    ,.perf_drained_o       (perf_drained)
    ,.perf_stall_o         (perf_stall)
`endif
  );

  always #5 clk = ~clk;

  // reference model state
  ent_t        sq_q[$];
  ent_t        infl;
  int          m_pend = 0;
  bit          outstanding = 1'b0;
  bit          drop = 1'b0;
  bit          f_exp = 1'b0;
  logic [5:0]  f_tag = 6'd0;
  logic [31:0] f_addr = 32'd0;
  int          m_drained = 0;
  int          n_hs = 0;
  int          n_checks = 0;
  int          n_fail = 0;
  // values sampled in the most recent cycle
  logic        s_req, s_pop, s_fault, s_idle;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic push(input logic [5:0] tag, input logic [31:0] addr,
                      input logic [31:0] data, input logic [3:0] be);
    ent_t e;
    e.tag = tag; e.addr = addr; e.data = data; e.be = be;
    sq_q.push_back(e);
  endtask

  // One clock cycle: present the SQ head, sample mid-cycle, check against the
  // model, advance the model, then move to just after the next rising edge.
  task automatic cyc();
    bit exp_pop;
    if (sq_q.size() > 0) begin
      head_valid = 1'b1;
      head_tag = sq_q[0].tag; head_addr = sq_q[0].addr;
      head_data = sq_q[0].data; head_be = sq_q[0].be;
    end else begin
      head_valid = 1'b0;
      head_tag = 6'd0; head_addr = 32'd0; head_data = 32'd0; head_be = 4'd0;
    end
    #4;
    s_req = req_valid; s_pop = pop; s_fault = fault; s_idle = idle;
    exp_pop = resp_valid && outstanding && !drop && !flush;
    chk("pop", s_pop, exp_pop);
    chk("pending", pending, m_pend);
    chk("idle", s_idle, (m_pend == 0) && !outstanding);
    chk("fault", s_fault, f_exp);
    chk("fault_tag", fault_tag, f_tag);
    chk("fault_addr", fault_addr, f_addr);
    if (s_req) begin
      chk("req_allowed", s_req, (m_pend > 0) && (sq_q.size() > 0));
      if (sq_q.size() > 0) begin
        chk("req_addr", req_addr, sq_q[0].addr);
        chk("req_data", req_wdata, sq_q[0].data);
        chk("req_strb", req_wstrb, sq_q[0].be);
      end
    end
`ifdef SQ_DRAIN_PERF_EN
    chk("perf_drained", perf_drained, m_drained);
`endif
    if (!rst_ni) begin
      sq_q.delete();
      m_pend = 0; outstanding = 1'b0; drop = 1'b0;
      f_exp = 1'b0; f_tag = 6'd0; f_addr = 32'd0; m_drained = 0;
    end else begin
      f_exp = 1'b0;
      if (resp_valid && outstanding) begin
        f_exp = resp_err;
        if (resp_err) begin
          f_tag = infl.tag; f_addr = infl.addr;
        end
        if (exp_pop && sq_q.size() > 0) void'(sq_q.pop_front());
        if (exp_pop) m_drained++;
        outstanding = 1'b0; drop = 1'b0;
      end
      if (s_req && ready && !flush && sq_q.size() > 0) begin
        infl = sq_q[0]; outstanding = 1'b1; n_hs++;
      end
      if (flush) begin
        m_pend = 0;
        if (outstanding) drop = 1'b1;
        sq_q.delete();
      end else begin
        m_pend = m_pend + int'(commit) - int'(exp_pop);
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic run_until_wait();
    for (int i = 0; i < 12 && !outstanding; i++) cyc();
    chk("wait_reached", outstanding, 1'b1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int hs0;
    rst_ni = 1'b0; flush = 1'b0; commit = 2'd0; ready = 1'b0;
    resp_valid = 1'b0; resp_err = 1'b0; head_valid = 1'b0;
    head_tag = 6'd0; head_addr = 32'd0; head_data = 32'd0; head_be = 4'd0;
    repeat (2) @(posedge clk);
    #1;
    rst_ni = 1'b1;
    #3;
    chk("rst_req", req_valid, 1'b0);
    chk("rst_pop", pop, 1'b0);
    chk("rst_idle", idle, 1'b1);
    chk("rst_pending", pending, 5'd0);
    chk("rst_fault", fault, 1'b0);
    chk("rst_addr", req_addr, 32'd0);
    @(posedge clk); #1;

    // single store: commit at T, request at T+2, response/pop at T+3
    push(6'd1, 32'h0000_1000, 32'hDEAD_BEEF, 4'hF);
    commit = 2'd1; ready = 1'b1;
    cyc(); chk("t0_req", s_req, 1'b0);
    commit = 2'd0;
    cyc(); chk("t1_req", s_req, 1'b0);
    cyc(); chk("t2_req", s_req, 1'b1);
    resp_valid = 1'b1;
    cyc(); chk("t3_pop", s_pop, 1'b1);
    resp_valid = 1'b0;
    cyc(); chk("t4_idle", s_idle, 1'b1);

    // backpressure: four cycles of ready low in REQ
    push(6'd2, 32'h0000_1100, 32'h1234_5678, 4'h3);
    commit = 2'd1; ready = 1'b0;
    cyc();
    commit = 2'd0;
    cyc();
    for (int i = 0; i < 4; i++) begin
      cyc(); chk("bp_req_held", s_req, 1'b1);
      chk("bp_no_pop", s_pop, 1'b0);
    end
    ready = 1'b1;
    cyc();
`ifdef SQ_DRAIN_PERF_EN
    chk("perf_stall", perf_stall, 32'd4);
`endif
    cyc(); chk("bp_wait_no_pop", s_pop, 1'b0);
    resp_valid = 1'b1;
    cyc(); chk("bp_pop", s_pop, 1'b1);
    resp_valid = 1'b0;

    // burst: commit 2 then 1, drain with immediate responses
    push(6'd10, 32'h0000_3000, 32'hA0A0_0001, 4'hF);
    push(6'd11, 32'h0000_3004, 32'hA0A0_0002, 4'hC);
    push(6'd12, 32'h0000_3008, 32'hA0A0_0003, 4'h1);
    hs0 = n_hs;
    commit = 2'd2;
    cyc();
    commit = 2'd1;
    cyc();
    commit = 2'd0;
    for (int i = 0; i < 40 && (m_pend > 0 || outstanding); i++) begin
      resp_valid = outstanding;
      cyc();
    end
    resp_valid = 1'b0;
    chk("burst_reqs", n_hs - hs0, 3);
    chk("burst_pending", pending, 5'd0);

    // error response: tag 5 addr 0x2004
    push(6'd5, 32'h0000_2004, 32'hCAFE_F00D, 4'hF);
    commit = 2'd1;
    cyc();
    commit = 2'd0;
    run_until_wait();
    resp_valid = 1'b1; resp_err = 1'b1;
    cyc(); chk("err_pop", s_pop, 1'b1);
    resp_valid = 1'b0; resp_err = 1'b0;
    cyc(); chk("err_fault", s_fault, 1'b1);
    chk("err_tag", fault_tag, 6'd5);
    chk("err_addr", fault_addr, 32'h0000_2004);
    cyc(); chk("err_pulse_end", s_fault, 1'b0);

    // flush in WAIT, response the following cycle
    push(6'd7, 32'h0000_4000, 32'h0BAD_0BAD, 4'hF);
    commit = 2'd1;
    cyc();
    commit = 2'd0;
    run_until_wait();
    flush = 1'b1;
    cyc();
    flush = 1'b0; resp_valid = 1'b1;
    cyc(); chk("flush_no_pop", s_pop, 1'b0);
    resp_valid = 1'b0;
    cyc(); chk("flush_idle", s_idle, 1'b1);
    chk("flush_pending", pending, 5'd0);

    // synchronous reset while in REQ
    push(6'd9, 32'h0000_5000, 32'h5555_AAAA, 4'hF);
    commit = 2'd1; ready = 1'b0;
    cyc();
    commit = 2'd0;
    cyc();
    cyc(); chk("rstmid_pre_req", s_req, 1'b1);
    rst_ni = 1'b0;
    cyc();
    rst_ni = 1'b1;
    cyc(); chk("rstmid_req", s_req, 1'b0);
    chk("rstmid_idle", s_idle, 1'b1);

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      int unret;
      int mx;
      if (sq_q.size() < 16 && ($urandom % 2) == 0)
        push(6'($urandom), $urandom, $urandom, 4'($urandom));
      unret = sq_q.size() - m_pend;
      mx = (unret < 2) ? unret : 2;
      flush = 1'b0;
      if (m_pend == 0 && !outstanding && ($urandom % 40) == 0) begin
        flush = 1'b1;
        commit = 2'd0;
      end else begin
        commit = 2'($urandom_range(mx));
      end
      ready = (($urandom % 3) != 0);
      resp_valid = outstanding && (($urandom % 2) == 0);
      resp_err = resp_valid && (($urandom % 4) == 0);
      cyc();
    end
    flush = 1'b0; commit = 2'd0; ready = 1'b1; resp_err = 1'b0;
    for (int i = 0; i < 200 && (m_pend > 0 || outstanding); i++) begin
      resp_valid = outstanding;
      cyc();
    end
    resp_valid = 1'b0;
    chk("drain_done", (m_pend == 0) && !outstanding, 1'b1);
    cyc();
    chk("final_idle", s_idle, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
